// File: rtl/dmem_pkg.sv
// dmem_pkg: size encodings, FSM states and defaults shared by the data-memory arbiter.
package dmem_pkg;

    localparam int MEM_BYTES_DEFAULT = 1024;

    localparam logic [1:0] NUM_ILL  = 2'b00;
    localparam logic [1:0] NUM_BYTE = 2'b01;
    localparam logic [1:0] NUM_HALF = 2'b10;
    localparam logic [1:0] NUM_WORD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    function automatic logic [2:0] size_bytes(input logic [1:0] num);
        return (num == NUM_WORD) ? 3'd4 :
               (num == NUM_HALF) ? 3'd2 :
               (num == NUM_BYTE) ? 3'd1 : 3'd0;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; the last-grant pointer resets to port 1 so port 0
// wins the first contention.
module rr_arb2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req0_i,
    input  logic req1_i,
    input  logic upd_i,
    input  logic upd_port_i,
    output logic gnt_o
);

    logic r_last;

    always_ff @(posedge clk_i) begin
        if (!rst_i)
            r_last <= 1'b1;
        else if (upd_i)
            r_last <= upd_port_i;
    end

    assign gnt_o = (req0_i && req1_i) ? ~r_last : req1_i;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the CPU (port 0) and DMA/loader (port 1).
// Define DMEM_ARB_ALIGN_CHK_EN to reject misaligned and out-of-range accesses with err.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_i,
    input  logic        req1_i,
    input  logic        we0_i,
    input  logic        we1_i,
    input  logic [31:0] addr0_i,
    input  logic [31:0] addr1_i,
    input  logic [31:0] wdata0_i,
    input  logic [31:0] wdata1_i,
    input  logic [1:0]  num0_i,
    input  logic [1:0]  num1_i,
    input  logic        uns0_i,
    input  logic        uns1_i,
    output logic        ack0_o,
    output logic        ack1_o,
    output logic        err0_o,
    output logic        err1_o,
    output logic [31:0] rdata_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic [1:0]  mem_num_o,
    output logic        mem_unsigned_o,
    input  logic [31:0] mem_data_i
);

`ifdef DMEM_ARB_ALIGN_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    state_t      r_state, w_next;
    logic        r_port, r_we, r_uns;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [1:0]  r_num;
    logic        w_any, w_gnt, w_legal, w_align, w_fit, w_ok;
    logic [2:0]  w_size;

    assign w_any = req0_i | req1_i;

    rr_arb2 u_rr (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req0_i     (req0_i),
        .req1_i     (req1_i),
        .upd_i      (r_state == ST_RESP),
        .upd_port_i (r_port),
        .gnt_o      (w_gnt)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = ST_IDLE;
        case (r_state)
            ST_IDLE:   w_next = w_any ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: w_next = ST_RESP;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Operands are captured once at grant so requester changes cannot disturb the access.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_port  <= 1'b0;
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_num   <= NUM_ILL;
        end else if (r_state == ST_IDLE && w_any) begin
            r_port  <= w_gnt;
            r_we    <= w_gnt ? we1_i    : we0_i;
            r_uns   <= w_gnt ? uns1_i   : uns0_i;
            r_addr  <= w_gnt ? addr1_i  : addr0_i;
            r_wdata <= w_gnt ? wdata1_i : wdata0_i;
            r_num   <= w_gnt ? num1_i   : num0_i;
        end
    end

    assign w_size  = size_bytes(r_num);
    assign w_legal = r_num != NUM_ILL;
    assign w_align = !((r_num == NUM_WORD && r_addr[1:0] != 2'b00) ||
                       (r_num == NUM_HALF && r_addr[0]));
    assign w_fit   = ({1'b0, r_addr} + {30'b0, w_size}) <= 33'(MEM_BYTES);
    assign w_ok    = w_legal && (!CHK_EN || (w_align && w_fit));

    // Rejected accesses also clear the read-data register.
    always_ff @(posedge clk_i) begin
        if (!rst_i)
            r_rdata <= '0;
        else if (r_state == ST_ACCESS && (!r_we || !w_ok))
            r_rdata <= w_ok ? mem_data_i : '0;
    end

    assign mem_read_o     = (r_state == ST_ACCESS) && !r_we && w_ok;
    assign mem_write_o    = (r_state == ST_ACCESS) &&  r_we && w_ok;
    assign mem_addr_o     = r_addr;
    assign mem_data_o     = r_wdata;
    assign mem_num_o      = r_num;
    assign mem_unsigned_o = r_uns;
    assign rdata_o        = r_rdata;
    assign ack0_o         = (r_state == ST_RESP) && !r_port;
    assign ack1_o         = (r_state == ST_RESP) &&  r_port;
    assign err0_o         = ack0_o && !w_ok;
    assign err1_o         = ack1_o && !w_ok;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized transactions checked against a transaction-level
// model of arbitration order, latency, error rules and read-data.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_ALIGN_CHK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        req0_i = 1'b0, req1_i = 1'b0, we0_i = 1'b0, we1_i = 1'b0;
    logic [31:0] addr0_i = '0, addr1_i = '0, wdata0_i = '0, wdata1_i = '0;
    logic [1:0]  num0_i = '0, num1_i = '0;
    logic        uns0_i = 1'b0, uns1_i = 1'b0;
    logic        ack0_o, ack1_o, err0_o, err1_o;
    logic [31:0] rdata_o, mem_addr_o, mem_data_o;
    logic        mem_read_o, mem_write_o, mem_unsigned_o;
    logic [1:0]  mem_num_o;
    logic [31:0] mem_data_i = '0;

    int          ntests = 0;
    int          nfail = 0;
    bit          last_gnt = 1'b1;
    logic [31:0] exp_rdata = '0;

    always #5 clk_i = ~clk_i;

    dmem_arbiter #(.MEM_BYTES(1024)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_i(req0_i), .req1_i(req1_i), .we0_i(we0_i), .we1_i(we1_i),
        .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
        .num0_i(num0_i), .num1_i(num1_i), .uns0_i(uns0_i), .uns1_i(uns1_i),
        .ack0_o(ack0_o), .ack1_o(ack1_o), .err0_o(err0_o), .err1_o(err1_o),
        .rdata_o(rdata_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_num_o(mem_num_o),
        .mem_unsigned_o(mem_unsigned_o), .mem_data_i(mem_data_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_err(input logic [1:0] n, input logic [31:0] a);
        int sz;
        sz = (n == 2'd3) ? 4 : (n == 2'd2) ? 2 : (n == 2'd1) ? 1 : 0;
        return (sz == 0) ||
               (ALIGN_CHK && ((a % sz != 0) || ({32'd0, a} + 64'(sz) > 64'd1024)));
    endfunction

    task automatic set_port(input bit p, input bit r, input bit we, input logic [31:0] a,
                            input logic [31:0] wd, input logic [1:0] n, input bit u);
        if (p) begin
            req1_i = r; we1_i = we; addr1_i = a; wdata1_i = wd; num1_i = n; uns1_i = u;
        end else begin
            req0_i = r; we0_i = we; addr0_i = a; wdata0_i = wd; num0_i = n; uns0_i = u;
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_ack0", ack0_o, 0);          chk("rst_ack1", ack1_o, 0);
        chk("rst_err0", err0_o, 0);          chk("rst_err1", err1_o, 0);
        chk("rst_mem_read", mem_read_o, 0);  chk("rst_mem_write", mem_write_o, 0);
        chk("rst_rdata", rdata_o, 0);        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_data", mem_data_o, 0);  chk("rst_mem_num", mem_num_o, 0);
        chk("rst_mem_uns", mem_unsigned_o, 0);
    endtask

    // One isolated transaction from an idle arbiter; operands are scrambled after grant.
    task automatic run_one(input bit p, input bit we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [1:0] n, input bit u, input logic [31:0] mv);
        bit e, got;
        int waited, nrd, nwr;
        e = exp_err(n, a);
        @(negedge clk_i);
        mem_data_i = mv;
        set_port(p, 1'b1, we, a, wd, n, u);
        got = 0; waited = 0; nrd = 0; nwr = 0;
        while (!got && waited < 8) begin
            @(negedge clk_i);
            waited++;
            if (mem_read_o || mem_write_o) begin
                nrd += int'(mem_read_o);
                nwr += int'(mem_write_o);
                chk("acc_addr", mem_addr_o, a);
                chk("acc_num", mem_num_o, n);
                chk("acc_uns", mem_unsigned_o, u);
                if (we) chk("acc_wdata", mem_data_o, wd);
            end
            if (waited == 1) set_port(p, 1'b1, $urandom_range(0, 1), $urandom, $urandom, 2'($urandom), 1'($urandom));
            got = p ? ack1_o : ack0_o;
            chk("stray_ack", p ? ack0_o : ack1_o, 0);
        end
        chk("ack_seen", got, 1);
        chk("latency", waited, 2);
        chk("err", p ? err1_o : err0_o, e);
        chk("read_cnt", nrd, (!we && !e) ? 1 : 0);
        chk("write_cnt", nwr, (we && !e) ? 1 : 0);
        if (e) exp_rdata = '0;
        else if (!we) exp_rdata = mv;
        chk("rdata", rdata_o, exp_rdata);
        chk("addr_hold", mem_addr_o, a);
        last_gnt = p;
        set_port(p, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
    endtask

    initial begin
        int acks, prev_k, k, waited;
        bit port;
        logic [31:0] a;
        repeat (3) @(negedge clk_i);
        chk_reset_vals();
        rst_i = 1'b1;

        run_one(0, 0, 32'h10, 32'h0, 2'b11, 0, 32'h1234_5678);
        run_one(1, 1, 32'h20, 32'hAB, 2'b01, 0, 32'h0);
        run_one(0, 0, 32'h13, 32'h0, 2'b11, 0, 32'hDEAD_BEEF);
        run_one(0, 0, 32'h8, 32'h0, 2'b00, 0, 32'h55);
        run_one(1, 0, 32'h3FC, 32'h0, 2'b11, 1, 32'hA5A5_0001);
        run_one(1, 1, 32'h3FE, 32'hBEEF, 2'b11, 0, 32'h0);
        run_one(0, 0, 32'h3FE, 32'h0, 2'b10, 1, 32'h0000_8001);
        run_one(0, 0, 32'h3FD, 32'h0, 2'b10, 0, 32'h0000_7002);
        run_one(0, 0, 32'h3FF, 32'h0, 2'b01, 1, 32'h0000_00C3);
        run_one(1, 0, 32'h400, 32'h0, 2'b01, 0, 32'h0000_00D4);

        // Both ports request continuously: grants alternate, one ack every 3 cycles.
        @(negedge clk_i);
        mem_data_i = 32'h0BAD_F00D;
        set_port(0, 1'b1, 1'b0, 32'h40, 32'h0, 2'b11, 1'b0);
        set_port(1, 1'b1, 1'b0, 32'h80, 32'h0, 2'b11, 1'b0);
        acks = 0; prev_k = 0; k = 0;
        while (acks < 6 && k < 40) begin
            @(negedge clk_i);
            k++;
            if (ack0_o || ack1_o) begin
                chk("cont_one_ack", ack0_o & ack1_o, 0);
                port = ack1_o;
                chk("cont_rr_port", port, !last_gnt);
                if (acks == 0) chk("cont_first_lat", k, 2);
                else chk("cont_gap", k - prev_k, 3);
                last_gnt = port;
                prev_k = k;
                acks++;
            end
        end
        chk("cont_acks", acks, 6);
        set_port(0, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
        set_port(1, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
        exp_rdata = 32'h0BAD_F00D;
        @(negedge clk_i);
        chk("cont_rdata", rdata_o, exp_rdata);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: a = 32'(1016 + $urandom_range(0, 12));
                1: a = 32'($urandom_range(0, 1023));
                default: a = $urandom;
            endcase
            run_one(1'($urandom), 1'($urandom), a, $urandom, 2'($urandom), 1'($urandom), $urandom);
        end

        // Reset while in ACCESS abandons the transaction; port 0 wins afterwards.
        run_one(0, 0, 32'h4, 32'h0, 2'b11, 0, 32'h7777_1234);
        @(negedge clk_i);
        mem_data_i = 32'h1111_2222;
        set_port(0, 1'b1, 1'b0, 32'h30, 32'h0, 2'b11, 1'b0);
        @(negedge clk_i);
        chk("rst_pre_read", mem_read_o, 1);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk_reset_vals();
        rst_i = 1'b1;
        last_gnt = 1'b1;
        set_port(1, 1'b1, 1'b0, 32'h34, 32'h0, 2'b11, 1'b0);
        waited = 0;
        while (!(ack0_o || ack1_o) && waited < 8) begin
            @(negedge clk_i);
            waited++;
        end
        chk("post_rst_port0", {ack1_o, ack0_o}, 2'b01);
        chk("post_rst_lat", waited, 2);
        chk("post_rst_err", err0_o, 0);
        chk("post_rst_rdata", rdata_o, 32'h1111_2222);
        set_port(0, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
        waited = 0;
        do begin
            @(negedge clk_i);
            waited++;
        end while (!(ack0_o || ack1_o) && waited < 8);
        chk("post_rst_port1", {ack1_o, ack0_o}, 2'b10);
        chk("post_rst_gap", waited, 3);
        set_port(1, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
        repeat (2) @(negedge clk_i);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
